ddr2_cmd_arbiter: RTL
=====================

Name: ddr2_cmd_arbiter

Overview:
- Shares the single DDR2 controller command/data interface between two requesters: the host port (high priority) and the background scrubber (low priority).
- Serialises commands and forwards write-data bursts to the controller. Once a write command is granted, its data words stay locked to that owner until the burst completes.
- Tracks outstanding reads in an owner-tag FIFO and steers returned read data to the requester that issued the read.
- Includes a starvation guard so host traffic cannot block scrubbing indefinitely.

Parameters:
- ADDR_WIDTH, 25, address width.
- RD_TAGS, 8, depth of the outstanding-read tag FIFO (power of 2).
- STARVE_LIMIT, 16, number of consecutive host grants allowed while scrub_req is pending before the scrubber is forced to win.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- host_req / scrub_req  in  1  command request; the command fields must be held stable while the request is high.
- host_cmd / scrub_cmd  in  3  command code: 001 SCR, 010 SCW, 011 BLR, 100 BLW.
- host_sz / scrub_sz  in  2  block size; a block carries 8*(sz+1) words.
- host_addr / scrub_addr  in  ADDR_WIDTH  command address.
- host_gnt / scrub_gnt  out  1  one-cycle pulse: command accepted.
- host_wvalid / scrub_wvalid  in  1  write word valid.
- host_wdata / scrub_wdata  in  64  write word.
- host_wrdy / scrub_wrdy  out  1  write word accepted this cycle.
- host_validout / scrub_validout  out  1  steered read-data valid.
- host_fetching / scrub_fetching  in  1  requester accepts the read word.
- rd_data  out  64  ctrl_data_out passed through.
- rd_addr  out  ADDR_WIDTH  ctrl_raddr passed through.
- ctrl_ready, ctrl_notfull  in  1  controller status.
- ctrl_cmd_put  out  1  enqueue command.
- ctrl_cmd  out  3  command code to controller.
- ctrl_sz  out  2  block size to controller.
- ctrl_addr  out  ADDR_WIDTH  address to controller.
- ctrl_data_put  out  1  enqueue write word.
- ctrl_data_in  out  64  write word to controller.
- ctrl_validout  in  1  controller read-data valid.
- ctrl_data_out  in  64  controller read data.
- ctrl_raddr  in  ADDR_WIDTH  controller return address.
- ctrl_fetching  out  1  read word accepted by the owning requester.
- tag_err  out  1  sticky: read data arrived with the tag FIFO empty.

Behaviour:
- Reset state: all grants, puts, wrdy, validout and tag_err are 0; ctrl_cmd/sz/addr are 0; tag FIFO is empty; starvation counter is 0; state is ARB.

States: ARB, BUBBLE, WDATA.

ARB:
- Arbitration is eligible when ctrl_ready && ctrl_notfull && (tag FIFO not full, or the candidate command is a write).
- Winner: scrubber if starve_cnt == STARVE_LIMIT and scrub_req is high; otherwise host if host_req; otherwise scrubber.
- On a grant, the following outputs are registered and seen in the next cycle (latency 1 from req sampled to put):
  - ctrl_cmd_put = 1 and the winner's gnt = 1, each for exactly one cycle.
  - ctrl_cmd/sz/addr = the winner's fields.
- Read grant (SCR or BLR): push {owner, word count}; count is 1 for SCR, 8*(sz+1) for BLR. Next state is BUBBLE.
- Write grant (SCW or BLW): load wcount (1 or 8*(sz+1)) and the owner. Next state is WDATA.

BUBBLE:
- One cycle with no grants, so the requester can drop its req. Then return to ARB.

WDATA (combinational forwarding):
- ctrl_data_put = owner_wvalid && ctrl_notfull.
- ctrl_data_in = owner_wdata.
- owner_wrdy = ctrl_notfull.
- The non-owner's wrdy stays 0.
- Each transfer decrements wcount. When the final word is accepted, return to ARB; no new command is granted in that cycle.
- Requests seen during WDATA wait.

Starvation counter:
- Increments on each host grant while scrub_req is high.
- Clears on a scrub grant or whenever scrub_req is low.
- Saturates at STARVE_LIMIT.

Read return (combinational):
- X_validout = ctrl_validout && FIFO non-empty && head.owner == X.
- ctrl_fetching = the owner's fetching && X_validout.
- Each accepted word decrements the head count; the head pops when its count reaches 0.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- If ctrl_validout is high with the FIFO empty: tag_err is set, ctrl_fetching = 1 so the word is drained, and no validout is raised.

Other boundary conditions:
- Simultaneous host_req and scrub_req with starve_cnt < STARVE_LIMIT: host wins.
- ctrl_notfull dropping mid-WDATA: transfers stall and wcount holds.
- Reset mid-burst: returns to the reset state immediately; partial bursts are abandoned.

Test Plan:
- Simultaneous host BLR sz=00 and scrub BLR sz=00 at addr 0x100 / 0x200 -> host_gnt at cycle+1, ctrl_addr=0x100; scrub_gnt after the BUBBLE, ctrl_addr=0x200. 16 returned words: first 8 go to host_validout, next 8 to scrub_validout.
- Host BLW sz=01 with wvalid always high and ctrl_notfull low for 3 cycles mid-burst -> exactly 16 ctrl_data_put pulses in order; the scrubber receives no grant until the last word is accepted.
- host_req held high continuously with scrub_req high, STARVE_LIMIT=16 -> the 17th grant goes to the scrubber; counter reads 0 afterwards.
- Issue 8 host SCRs with reads not returned, RD_TAGS=8 -> the 9th read is not granted; a host SCW is still granted; after one word returns, the 9th read is granted.
- ctrl_validout pulse with the tag FIFO empty -> tag_err=1 and sticky, ctrl_fetching=1, both validouts 0.
- Reset asserted at the 4th word of a BLW -> next cycle: state ARB, ctrl_data_put=0, FIFO empty, all outputs at their reset values.

Source files
------------

// File: rtl/ddr2_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// ddr2_cmd_arbiter - host/scrubber arbiter for one DDR2 controller port (rev 1.0)
// ============================================================================
module ddr2_cmd_arbiter #(
  parameter int ADDR_WIDTH   = 25,
  parameter int RD_TAGS      = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_req,
  input  logic                  scrub_req,
  input  logic [2:0]            host_cmd,
  input  logic [2:0]            scrub_cmd,
  input  logic [1:0]            host_sz,
  input  logic [1:0]            scrub_sz,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [ADDR_WIDTH-1:0] scrub_addr,
  output logic                  host_gnt,
  output logic                  scrub_gnt,
  input  logic                  host_wvalid,
  input  logic                  scrub_wvalid,
  input  logic [63:0]           host_wdata,
  input  logic [63:0]           scrub_wdata,
  output logic                  host_wrdy,
  output logic                  scrub_wrdy,
  output logic                  host_validout,
  output logic                  scrub_validout,
  input  logic                  host_fetching,
  input  logic                  scrub_fetching,
  output logic [63:0]           rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  ctrl_ready,
  input  logic                  ctrl_notfull,
  output logic                  ctrl_cmd_put,
  output logic [2:0]            ctrl_cmd,
  output logic [1:0]            ctrl_sz,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic                  ctrl_data_put,
  output logic [63:0]           ctrl_data_in,
  input  logic                  ctrl_validout,
  input  logic [63:0]           ctrl_data_out,
  input  logic [ADDR_WIDTH-1:0] ctrl_raddr,
  output logic                  ctrl_fetching,
  output logic                  tag_err
);

  localparam int PW = $clog2(RD_TAGS);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = 6;
  localparam logic [2:0] CMD_SCR = 3'b001;
  localparam logic [2:0] CMD_SCW = 3'b010;
  localparam logic [2:0] CMD_BLW = 3'b100;

  typedef enum logic [1:0] {ARB = 2'd0, BUBBLE = 2'd1, WDATA = 2'd2} state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic            wowner;
  logic [CW-1:0]   wcount;
  logic            tag_owner [RD_TAGS];
  logic [CW-1:0]   tag_cnt   [RD_TAGS];
  logic [PW-1:0]   rptr, wptr;
  logic [PW:0]     occ;

  logic                  pick_scrub, c_write, grant, push, pop, rd_accept;
  logic                  fifo_full, fifo_empty, head_owner, own_wvalid;
  logic [2:0]            c_cmd;
  logic [1:0]            c_sz;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [CW-1:0]         c_words, head_cnt;

  // Scrubber wins only when forced by starvation or when the host is idle.
  assign pick_scrub = scrub_req && ((starve_cnt == SW'(STARVE_LIMIT)) || !host_req);
  assign c_cmd      = pick_scrub ? scrub_cmd  : host_cmd;
  assign c_sz       = pick_scrub ? scrub_sz   : host_sz;
  assign c_addr     = pick_scrub ? scrub_addr : host_addr;
  assign c_write    = (c_cmd == CMD_SCW) || (c_cmd == CMD_BLW);
  assign c_words    = ((c_cmd == CMD_SCR) || (c_cmd == CMD_SCW)) ? CW'(1)
                                                                 : CW'({c_sz, 3'b000}) + CW'(8);
  assign fifo_full  = (occ == (PW+1)'(RD_TAGS));
  assign fifo_empty = (occ == '0);
  assign grant      = (state == ARB) && (host_req || scrub_req) && ctrl_ready &&
                      ctrl_notfull && (!fifo_full || c_write);
  assign push       = grant && !c_write;

  assign own_wvalid    = wowner ? scrub_wvalid : host_wvalid;
  assign ctrl_data_put = (state == WDATA) && own_wvalid && ctrl_notfull;
  assign ctrl_data_in  = wowner ? scrub_wdata : host_wdata;
  assign host_wrdy     = (state == WDATA) && !wowner && ctrl_notfull;
  assign scrub_wrdy    = (state == WDATA) &&  wowner && ctrl_notfull;

  assign head_owner     = tag_owner[rptr];
  assign head_cnt       = tag_cnt[rptr];
  assign host_validout  = ctrl_validout && !fifo_empty && !head_owner;
  assign scrub_validout = ctrl_validout && !fifo_empty &&  head_owner;
  // Untagged return data is drained so the controller never wedges.
  assign ctrl_fetching  = (host_fetching && host_validout) ||
                          (scrub_fetching && scrub_validout) ||
                          (ctrl_validout && fifo_empty);
  assign rd_accept      = ctrl_fetching && !fifo_empty;
  assign pop            = rd_accept && (head_cnt == CW'(1));
  assign rd_data        = ctrl_data_out;
  assign rd_addr        = ctrl_raddr;

  always_ff @(posedge clk) begin
    if (push) begin
      tag_owner[wptr] <= pick_scrub;
      tag_cnt[wptr]   <= c_words;
    end
    if (rd_accept && !pop) tag_cnt[rptr] <= head_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB;
      host_gnt     <= 1'b0;
      scrub_gnt    <= 1'b0;
      ctrl_cmd_put <= 1'b0;
      ctrl_cmd     <= '0;
      ctrl_sz      <= '0;
      ctrl_addr    <= '0;
      tag_err      <= 1'b0;
      starve_cnt   <= '0;
      wowner       <= 1'b0;
      wcount       <= '0;
      rptr         <= '0;
      wptr         <= '0;
      occ          <= '0;
    end else begin
      host_gnt     <= 1'b0;
      scrub_gnt    <= 1'b0;
      ctrl_cmd_put <= 1'b0;
      if (ctrl_validout && fifo_empty) tag_err <= 1'b1;

      if (!scrub_req || (grant && pick_scrub))
        starve_cnt <= '0;
      else if (grant && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);

      case (state)
        ARB: begin
          if (grant) begin
            ctrl_cmd_put <= 1'b1;
            host_gnt     <= !pick_scrub;
            scrub_gnt    <= pick_scrub;
            ctrl_cmd     <= c_cmd;
            ctrl_sz      <= c_sz;
            ctrl_addr    <= c_addr;
            if (c_write) begin
              wcount <= c_words;
              wowner <= pick_scrub;
              state  <= WDATA;
            end else begin
              state  <= BUBBLE;
            end
          end
        end
        BUBBLE: state <= ARB;
        WDATA: begin
          if (ctrl_data_put) begin
            wcount <= wcount - CW'(1);
            if (wcount == CW'(1)) state <= ARB;
          end
        end
        default: state <= ARB;
      endcase

      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule
`default_nettype wire
